// File: rtl/instr_sequencer_if.sv
// Memory-side handshake bundle for instr_sequencer.
//   imem_req   : program memory read request (sequencer -> memory)
//   imem_ack   : program memory data valid   (memory -> sequencer)
//   imem_rdata : fetched instruction word    (memory -> sequencer)
//   dmem_req   : data memory request         (sequencer -> memory)
//   dmem_we    : data memory write, qualified by dmem_req
//   dmem_ack   : data memory access complete (memory -> sequencer)
// Handshake rule for both channels: the request is held high until the
// cycle in which ack is sampled high at a rising clk edge; that cycle
// completes the transfer. An ack seen while no request is up is ignored.
interface instr_sequencer_if;
    logic        imem_req;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        dmem_req;
    logic        dmem_we;
    logic        dmem_ack;

    modport master (
        output imem_req,
        input  imem_ack,
        input  imem_rdata,
        output dmem_req,
        output dmem_we,
        input  dmem_ack
    );

    modport slave (
        input  imem_req,
        output imem_ack,
        output imem_rdata,
        input  dmem_req,
        input  dmem_we,
        output dmem_ack
    );
endinterface

// File: rtl/instr_sequencer.sv
// Multi-cycle phase sequencer for an RV32I core. Fetches an instruction,
// holds it for the control unit, then walks DECODE/EXECUTE/MEMORY/WRITEBACK,
// gating register-file writes, data-memory access and PC update to one
// qualified cycle each. Provides a trap state, halt request and counters.
// Ports:
//   clk, rst_n        : clock (rising edge), async active-low reset
//   start, halt_req   : leave IDLE / stop after the current instruction retires
//   bus (master)      : imem/dmem request-ack handshakes (instr_sequencer_if)
//   instr_q           : latched instruction for the control unit
//   cu_*              : control unit decode results for instr_q
//   rf_we, pc_en      : gated register-file write and PC update strobes
//   trap, trap_cause  : stopped on error; 01 illegal, 10 memory timeout
//   state             : current FSM state (debug/observability)
//   cycle_cnt         : cycles spent outside IDLE and TRAP
//   instret_cnt       : retired instructions
// Every output is decoded from flops only; no input reaches an output
// combinationally.
module instr_sequencer #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                halt_req,
    instr_sequencer_if.master   bus,
    output logic [31:0]         instr_q,
    input  logic                cu_w_en_rf,
    input  logic                cu_wr_en_dmem,
    input  logic [1:0]          cu_rf_w_select,
    input  logic                cu_illegal,
    output logic                rf_we,
    output logic                pc_en,
    output logic                trap,
    output logic [1:0]          trap_cause,
    output logic [2:0]          state,
    output logic [31:0]         cycle_cnt,
    output logic [31:0]         instret_cnt
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FETCH     = 3'd1,
        DECODE    = 3'd2,
        EXECUTE   = 3'd3,
        MEMORY    = 3'd4,
        WRITEBACK = 3'd5,
        TRAP      = 3'd6
    } state_e;

    localparam int unsigned TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    state_e      state_q, state_d;
    logic [31:0] instr_d;
    logic [1:0]  cause_q, cause_d;
    logic [TW-1:0] tmo_q, tmo_d;
    // Control-unit enables captured in EXECUTE so that dmem_we and rf_we
    // are flop-driven; instr_q is stable, so the values cannot change later.
    logic        mem_we_q, mem_we_d;
    logic        rf_en_q, rf_en_d;
    logic [31:0] cycle_q, cycle_d;
    logic [31:0] instret_q, instret_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            instr_q   <= 32'h0000_0013;
            cause_q   <= 2'b00;
            tmo_q     <= '0;
            mem_we_q  <= 1'b0;
            rf_en_q   <= 1'b0;
            cycle_q   <= 32'd0;
            instret_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            instr_q   <= instr_d;
            cause_q   <= cause_d;
            tmo_q     <= tmo_d;
            mem_we_q  <= mem_we_d;
            rf_en_q   <= rf_en_d;
            cycle_q   <= cycle_d;
            instret_q <= instret_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        instr_d   = instr_q;
        cause_d   = cause_q;
        tmo_d     = tmo_q;
        mem_we_d  = mem_we_q;
        rf_en_d   = rf_en_q;
        cycle_d   = cycle_q;
        instret_d = instret_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = FETCH;
                    tmo_d   = '0;
                end
            end
            FETCH: begin
                // An ack in the last allowed cycle beats the timeout.
                if (bus.imem_ack) begin
                    instr_d = bus.imem_rdata;
                    state_d = DECODE;
                end else if (tmo_q == TMO_LAST) begin
                    state_d = TRAP;
                    cause_d = 2'b10;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            DECODE: begin
                if (cu_illegal) begin
                    state_d = TRAP;
                    cause_d = 2'b01;
                end else begin
                    state_d = EXECUTE;
                end
            end
            EXECUTE: begin
                mem_we_d = cu_wr_en_dmem;
                rf_en_d  = cu_w_en_rf;
                if (cu_rf_w_select == 2'b01 || cu_wr_en_dmem) begin
                    state_d = MEMORY;
                    tmo_d   = '0;
                end else begin
                    state_d = WRITEBACK;
                end
            end
            MEMORY: begin
                if (bus.dmem_ack) begin
                    state_d = WRITEBACK;
                end else if (tmo_q == TMO_LAST) begin
                    state_d = TRAP;
                    cause_d = 2'b10;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            WRITEBACK: begin
                instret_d = instret_q + 32'd1;
                if (halt_req) begin
                    state_d = IDLE;
                end else begin
                    state_d = FETCH;
                    tmo_d   = '0;
                end
            end
            TRAP: begin
                state_d = TRAP;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (state_q inside {FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK}) begin
            cycle_d = cycle_q + 32'd1;
        end
    end

    assign bus.imem_req = (state_q == FETCH);
    assign bus.dmem_req = (state_q == MEMORY);
    assign bus.dmem_we  = (state_q == MEMORY) && mem_we_q;
    assign rf_we        = (state_q == WRITEBACK) && rf_en_q;
    assign pc_en        = (state_q == WRITEBACK);
    assign trap         = (state_q == TRAP);
    assign trap_cause   = cause_q;
    assign state        = state_q;
    assign cycle_cnt    = cycle_q;
    assign instret_cnt  = instret_q;

endmodule

// File: tb/tb_instr_sequencer.sv
module tb_instr_sequencer;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        start, halt_req;
    logic [31:0] instr_q;
    logic        cu_w_en_rf, cu_wr_en_dmem, cu_illegal;
    logic [1:0]  cu_rf_w_select;
    logic        rf_we, pc_en, trap;
    logic [1:0]  trap_cause;
    logic [2:0]  state;
    logic [31:0] cycle_cnt, instret_cnt;

    instr_sequencer_if bus();

    instr_sequencer #(.TIMEOUT(16)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .halt_req       (halt_req),
        .bus            (bus),
        .instr_q        (instr_q),
        .cu_w_en_rf     (cu_w_en_rf),
        .cu_wr_en_dmem  (cu_wr_en_dmem),
        .cu_rf_w_select (cu_rf_w_select),
        .cu_illegal     (cu_illegal),
        .rf_we          (rf_we),
        .pc_en          (pc_en),
        .trap           (trap),
        .trap_cause     (trap_cause),
        .state          (state),
        .cycle_cnt      (cycle_cnt),
        .instret_cnt    (instret_cnt)
    );

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    // One record per instruction: what must be observed by its retire cycle.
    typedef struct packed {
        logic [7:0]  lat;      // FETCH entry .. WRITEBACK inclusive
        logic [7:0]  rf_cyc;   // cycles with rf_we high
        logic [7:0]  mem_cyc;  // cycles with dmem_req high
        logic [7:0]  we_cyc;   // cycles with dmem_we high
        logic [31:0] ret;      // instret_cnt during WRITEBACK
        logic [31:0] instr;    // instr_q during WRITEBACK
    } exp_t;
    localparam int EXP_W = $bits(exp_t);
    logic [EXP_W-1:0] exp_q[$];

    // monitor
    logic mon_en = 1'b0;
    int   cyc, fstart, mcyc, wcyc, rcyc;
    logic prev_ireq;

    always @(negedge clk) begin
        exp_t e;
        if (!mon_en) begin
            cyc = 0; prev_ireq = 1'b0;
        end else begin
            cyc++;
            if (bus.imem_req && !prev_ireq) begin
                fstart = cyc; mcyc = 0; wcyc = 0; rcyc = 0;
            end
            if (bus.dmem_req) mcyc++;
            if (bus.dmem_we)  wcyc++;
            if (rf_we)        rcyc++;
            if (pc_en) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_retire", 32'd1, 32'd0);
                end else begin
                    e = exp_t'(exp_q.pop_front());
                    check("latency",   32'(cyc - fstart + 1), 32'(e.lat));
                    check("rf_we_cyc", 32'(rcyc),             32'(e.rf_cyc));
                    check("dmem_cyc",  32'(mcyc),             32'(e.mem_cyc));
                    check("dmem_we",   32'(wcyc),             32'(e.we_cyc));
                    check("instret",   instret_cnt,           e.ret);
                    check("instr_q",   instr_q,               e.instr);
                end
            end
            prev_ireq = bus.imem_req;
        end
    end

    // ---------------- driver tasks ----------------
    int unsigned exp_cycles;
    int unsigned exp_ret;

    task automatic do_reset();
        mon_en = 1'b0;
        rst_n = 1'b0;
        start = 1'b0; halt_req = 1'b0;
        bus.imem_ack = 1'b0; bus.imem_rdata = 32'h0; bus.dmem_ack = 1'b0;
        cu_w_en_rf = 1'b0; cu_wr_en_dmem = 1'b0; cu_rf_w_select = 2'b00; cu_illegal = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_state"},   32'(state),         32'd0);
        check({tag, "_instr"},   instr_q,            32'h0000_0013);
        check({tag, "_trap"},    32'(trap),          32'd0);
        check({tag, "_cause"},   32'(trap_cause),    32'd0);
        check({tag, "_ireq"},    32'(bus.imem_req),  32'd0);
        check({tag, "_dreq"},    32'(bus.dmem_req),  32'd0);
        check({tag, "_dwe"},     32'(bus.dmem_we),   32'd0);
        check({tag, "_rfwe"},    32'(rf_we),         32'd0);
        check({tag, "_pcen"},    32'(pc_en),         32'd0);
        check({tag, "_cycle"},   cycle_cnt,          32'd0);
        check({tag, "_instret"}, instret_cnt,        32'd0);
    endtask

    // Waits (bounded) at negedges until the chosen request is high.
    task automatic wait_req(input bit dmem, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if ((dmem ? bus.dmem_req : bus.imem_req) === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    // kind: 0 = ALU/branch/jump, 1 = load, 2 = store
    task automatic run_instr(input logic [31:0] ins, input int kind, input logic wen,
                             input int idly, input int ddly, input logic last);
        exp_t e;
        bit ok;
        int unsigned lat;
        wait_req(1'b0, ok);
        if (!ok) begin check("imem_req_wait", 32'd0, 32'd1); return; end
        for (int i = 0; i < idly; i++) begin
            bus.dmem_ack = 1'($urandom_range(0, 1));  // stray ack, must be ignored
            @(negedge clk);
        end
        bus.dmem_ack     = 1'b0;
        bus.imem_ack     = 1'b1;
        bus.imem_rdata   = ins;
        cu_illegal       = 1'b0;
        cu_w_en_rf       = wen;
        cu_wr_en_dmem    = (kind == 2);
        case (kind)
            1:       cu_rf_w_select = 2'b01;
            2:       cu_rf_w_select = 2'b00;
            default: begin
                case ($urandom_range(0, 2))
                    0:       cu_rf_w_select = 2'b00;
                    1:       cu_rf_w_select = 2'b10;
                    default: cu_rf_w_select = 2'b11;
                endcase
            end
        endcase
        halt_req = last;
        // reference model: 4 base phases, +1 MEMORY phase, +1 per wait cycle
        lat = 4 + idly + ((kind != 0) ? (1 + ddly) : 0);
        e.lat     = 8'(lat);
        e.rf_cyc  = 8'(wen);
        e.mem_cyc = (kind != 0) ? 8'(1 + ddly) : 8'd0;
        e.we_cyc  = (kind == 2) ? 8'(1 + ddly) : 8'd0;
        e.ret     = exp_ret;
        e.instr   = ins;
        exp_q.push_back(EXP_W'(e));
        exp_ret++;
        exp_cycles += lat;
        @(negedge clk);
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = $urandom;
        if (kind != 0) begin
            wait_req(1'b1, ok);
            if (!ok) begin check("dmem_req_wait", 32'd0, 32'd1); return; end
            for (int i = 0; i < ddly; i++) begin
                bus.imem_ack   = 1'($urandom_range(0, 1));  // stray ack, must be ignored
                bus.imem_rdata = $urandom;
                @(negedge clk);
            end
            bus.imem_ack = 1'b0;
            bus.dmem_ack = 1'b1;
            @(negedge clk);
            bus.dmem_ack = 1'b0;
        end
    endtask

    task automatic run_program(input int n);
        int kind;
        logic wen;
        do_reset();
        exp_cycles = 0;
        exp_ret    = 0;
        @(negedge clk);
        mon_en = 1'b1;
        pulse_start();
        check("start_latency_ireq", 32'(bus.imem_req), 32'd1);
        for (int i = 0; i < n; i++) begin
            kind = int'($urandom_range(0, 2));
            wen  = (kind == 1) ? 1'b1 : (kind == 2) ? 1'b0 : 1'($urandom_range(0, 1));
            run_instr($urandom, kind, wen, int'($urandom_range(0, 4)),
                      int'($urandom_range(0, 4)), (i == n - 1));
        end
        for (int i = 0; i < 20; i++) begin
            if (state == 3'd0) break;
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
        check("halt_state",   32'(state),        32'd0);
        check("halt_ireq",    32'(bus.imem_req), 32'd0);
        check("halt_instret", instret_cnt,       32'(n));
        check("halt_cycles",  cycle_cnt,         exp_cycles);
        check("queue_empty",  32'(exp_q.size()), 32'd0);
        halt_req = 1'b0;
        mon_en   = 1'b0;
        exp_q.delete();
    endtask

    // ---------------- test sequence ----------------
    initial begin
        bit ok;
        do_reset();
        @(negedge clk);
        check_reset_vals("reset0");

        // randomized program, halted on the last instruction
        run_program(24);
        // halt from the second instruction: exactly two retire
        run_program(2);

        // illegal instruction trap
        do_reset();
        pulse_start();
        bus.imem_ack = 1'b1; bus.imem_rdata = 32'hFFFF_FFFF; cu_illegal = 1'b1;
        @(negedge clk);
        bus.imem_ack = 1'b0;
        @(negedge clk);
        check("ill_state",  32'(state),      32'd6);
        check("ill_cycle0", cycle_cnt,       32'd2);
        for (int i = 0; i < 50; i++) begin
            bus.imem_ack = 1'($urandom_range(0, 1));
            bus.dmem_ack = 1'($urandom_range(0, 1));
            start        = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        bus.imem_ack = 1'b0; bus.dmem_ack = 1'b0; start = 1'b0;
        check("ill_state50", 32'(state),       32'd6);
        check("ill_trap",    32'(trap),        32'd1);
        check("ill_cause",   32'(trap_cause),  32'd1);
        check("ill_cycle50", cycle_cnt,        32'd2);
        check("ill_ireq",    32'(bus.imem_req),32'd0);
        check("ill_pcen",    32'(pc_en),       32'd0);
        #2 rst_n = 1'b0;
        #1 check_reset_vals("trap_rst");

        // fetch timeout: imem never acks
        do_reset();
        pulse_start();
        repeat (15) @(negedge clk);
        check("tmo_f_state15", 32'(state), 32'd1);
        @(negedge clk);
        check("tmo_f_state16", 32'(state),      32'd6);
        check("tmo_f_cause",   32'(trap_cause), 32'd2);

        // ack in the 16th fetch cycle wins over the timeout
        do_reset();
        pulse_start();
        repeat (15) @(negedge clk);
        bus.imem_ack = 1'b1; bus.imem_rdata = 32'h0050_0093;
        cu_rf_w_select = 2'b00; cu_w_en_rf = 1'b1;
        @(negedge clk);
        bus.imem_ack = 1'b0;
        check("tmo_ack_state", 32'(state), 32'd2);
        check("tmo_ack_trap",  32'(trap),  32'd0);
        check("tmo_ack_instr", instr_q,    32'h0050_0093);

        // load whose dmem never acks: memory timeout
        do_reset();
        pulse_start();
        bus.imem_ack = 1'b1; bus.imem_rdata = 32'h0000_A103;
        cu_rf_w_select = 2'b01; cu_w_en_rf = 1'b1;
        @(negedge clk);
        bus.imem_ack = 1'b0;
        wait_req(1'b1, ok);
        check("mtmo_req_seen", 32'(ok), 32'd1);
        repeat (15) @(negedge clk);
        check("mtmo_state15", 32'(state), 32'd4);
        @(negedge clk);
        check("mtmo_state16", 32'(state),      32'd6);
        check("mtmo_cause",   32'(trap_cause), 32'd2);

        // reset mid-MEMORY drops the request immediately, nothing retires
        do_reset();
        pulse_start();
        bus.imem_ack = 1'b1; bus.imem_rdata = 32'h0000_A103;
        cu_rf_w_select = 2'b01; cu_w_en_rf = 1'b1;
        @(negedge clk);
        bus.imem_ack = 1'b0;
        wait_req(1'b1, ok);
        repeat (3) @(negedge clk);
        check("mrst_dreq_before", 32'(bus.dmem_req), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("mrst_dreq",    32'(bus.dmem_req), 32'd0);
        check("mrst_instret", instret_cnt,       32'd0);
        check("mrst_state",   32'(state),        32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
